stage_executor: RTL and testbench

Worker-side counterpart of the stage sequencer: watches the 3-bit stage code and `done` flag broadcast by `state_control`, performs the work for each stage as a burst of read beats, and returns the one-cycle `finish` pulse that advances the sequencer. It sits between `state_control` and the accelerator datapath or buffer read port, and closes the stage handshake loop.

---
 rtl/stage_executor.sv | 86 ++++++++
 tb/tb_stage_executor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_executor.sv
// stage_executor: runs each sequencer stage as a burst of read beats and answers with a one-cycle finish.
module stage_executor #(
    parameter int ADDR_W = 16,
    parameter int LEN_S1 = 64,
    parameter int LEN_S2 = 576,
    parameter int LEN_S3 = 144,
    parameter int LEN_S4 = 16,
    parameter int LEN_S5 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        state,
    input  logic              done,
    input  logic              stall,
    output logic              finish,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        cur_stage,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, FIN, HOLD} fsm_t;
    fsm_t fsm, fsm_n;
    logic [ADDR_W:0] cnt, len;
    logic [2:0] eff;
    logic go_idle, start, beat, fin_n;
    assign eff = (state > 3'd5) ? 3'd0 : state;
    assign len = (ADDR_W+1)'(cur_stage == 3'd1 ? LEN_S1 :
                             cur_stage == 3'd2 ? LEN_S2 :
                             cur_stage == 3'd3 ? LEN_S3 :
                             cur_stage == 3'd4 ? LEN_S4 : LEN_S5);
    always_comb begin
        go_idle = 1'b0;
        start = 1'b0;
        beat = 1'b0;
        fin_n = 1'b0;
        fsm_n = fsm;
        if (done) begin
            go_idle = 1'b1;
        end else begin
            case (fsm)
                IDLE: start = eff != 3'd0;
                RUN: begin
                    if (eff != cur_stage) begin
                        go_idle = eff == 3'd0;
                        start = eff != 3'd0;
                    end else if (cnt == len) begin
                        fsm_n = FIN;
                        fin_n = 1'b1;
                    end else begin
                        beat = !stall;
                    end
                end
                FIN: fsm_n = HOLD;
                HOLD: begin
                    go_idle = eff == 3'd0;
                    start = eff != 3'd0 && eff != cur_stage;
                end
            endcase
        end
        if (go_idle) fsm_n = IDLE;
        if (start) fsm_n = RUN;
    end
    // cnt reaches LEN once the last beat is out; the extra bit keeps LEN = 2^ADDR_W representable
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            cnt <= '0;
            finish <= 1'b0;
            rd_en <= 1'b0;
            addr <= '0;
            cur_stage <= 3'd0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            fsm <= fsm_n;
            cnt <= (go_idle || start) ? (ADDR_W+1)'(start && !stall) : cnt + (ADDR_W+1)'(beat);
            finish <= fin_n;
            rd_en <= beat || (start && !stall);
            addr <= (go_idle || start) ? '0 : beat ? cnt[ADDR_W-1:0] : addr;
            cur_stage <= go_idle ? 3'd0 : start ? eff : cur_stage;
            busy <= fsm_n == RUN || fsm_n == FIN;
            err <= err || state > 3'd5;
        end
    end
endmodule

// File: tb/tb_stage_executor.sv
// tb_stage_executor: randomized stage runs checked cycle by cycle against a beat-count reference.
module tb_stage_executor;
    localparam int ADDR_W = 16;
    logic clk = 1'b0, rst = 1'b1, done = 1'b0, stall = 1'b0;
    logic [2:0] state = 3'd0;
    logic finish, rd_en, busy, err;
    logic [ADDR_W-1:0] addr;
    logic [2:0] cur_stage;
    int checks = 0, errors = 0, beats = 0;
    logic m_err = 1'b0;
    int lens [8] = '{0, 64, 576, 144, 16, 10, 0, 0};

    stage_executor #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .state(state), .done(done), .stall(stall),
        .finish(finish), .rd_en(rd_en), .addr(addr), .cur_stage(cur_stage),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat k appears in the cycle after the k-th edge sampled with stall low; finish follows the last beat.
    task automatic run_stage(input logic [2:0] s, input int pct, input int stop, output int cyc);
        int len, lim, n, w;
        logic b;
        logic [ADDR_W-1:0] ea;
        len = lens[s];
        lim = (stop > 0) ? stop : len;
        n = 0;
        w = 0;
        cyc = 0;
        state = s;
        while (n < lim && cyc < 4000) begin
            stall = (pct < 0) ? ((n == 3 && w < 3) || (n == 9 && w < 1)) : ($urandom_range(99) < pct);
            b = !stall;
            tick();
            cyc++;
            ea = ADDR_W'(b ? n : (n > 0 ? n - 1 : 0));
            checks++;
            if (rd_en !== b || finish !== 1'b0 || busy !== 1'b1 || cur_stage !== s || err !== m_err) begin
                errors++;
                $display("FAIL beat s%0d n%0d: rd_en %b finish %b busy %b stage %0d err %b, want rd_en %b finish 0 busy 1 stage %0d err %b",
                         s, n, rd_en, finish, busy, cur_stage, err, b, s, m_err);
            end
            checks++;
            if (addr !== ea) begin
                errors++;
                $display("FAIL addr s%0d n%0d: got %0d want %0d", s, n, addr, ea);
            end
            if (b) begin
                n++;
                w = 0;
                beats++;
            end else begin
                w++;
            end
        end
        checks++;
        if (n != lim) begin
            errors++;
            $display("FAIL timeout s%0d: issued %0d want %0d", s, n, lim);
        end
        if (stop > 0) return;
        stall = 1'($urandom_range(1));
        tick();
        checks++;
        if (finish !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL finish s%0d: finish %b rd_en %b busy %b want 1 0 1", s, finish, rd_en, busy);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (finish !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || cur_stage !== s) begin
            errors++;
            $display("FAIL after_finish s%0d: finish %b rd_en %b busy %b stage %0d want 0 0 0 %0d",
                     s, finish, rd_en, busy, cur_stage, s);
        end
    endtask

    task automatic expect_idle(input string tag);
        checks++;
        if (rd_en !== 1'b0 || finish !== 1'b0 || busy !== 1'b0 || cur_stage !== 3'd0 || addr !== '0 || err !== m_err) begin
            errors++;
            $display("FAIL %s: rd_en %b finish %b busy %b stage %0d addr %0d err %b want 0 0 0 0 0 %b",
                     tag, rd_en, finish, busy, cur_stage, addr, err, m_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            state = 3'($urandom_range(7));
            tick();
            expect_idle("reset");
        end
        state = 3'd0;
        rst = 1'b0;
        tick();
        expect_idle("idle_after_reset");
    endtask

    task automatic test_single();
        int c;
        run_stage(3'd4, 0, 0, c);
        checks++;
        if (c != 16) begin
            errors++;
            $display("FAIL single_len: cycles %0d want 16", c);
        end
    endtask

    task automatic test_stall();
        int c;
        run_stage(3'd5, -1, 0, c);
        checks++;
        if (c != 14) begin
            errors++;
            $display("FAIL stall_len: cycles %0d want 14", c);
        end
    endtask

    task automatic test_hold_done();
        for (int i = 0; i < 20; i++) begin
            stall = 1'($urandom_range(1));
            tick();
            checks++;
            if (rd_en !== 1'b0 || finish !== 1'b0 || busy !== 1'b0 || cur_stage !== 3'd5) begin
                errors++;
                $display("FAIL hold: rd_en %b finish %b busy %b stage %0d want 0 0 0 5", rd_en, finish, busy, cur_stage);
            end
        end
        stall = 1'b0;
        done = 1'b1;
        state = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle("done_priority");
        end
        done = 1'b0;
        state = 3'd0;
        tick();
        expect_idle("idle_after_done");
    endtask

    task automatic test_abort();
        int c;
        run_stage(3'd2, 0, 100, c);
        run_stage(3'd3, 0, 0, c);
        checks++;
        if (c != 144) begin
            errors++;
            $display("FAIL abort_len: cycles %0d want 144", c);
        end
    endtask

    task automatic test_reserved();
        int c;
        run_stage(3'd1, 0, 20, c);
        state = 3'd6;
        m_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle("reserved");
        end
        state = 3'd7;
        tick();
        expect_idle("reserved7");
        run_stage(3'd2, 20, 0, c);
        rst = 1'b1;
        state = 3'd0;
        m_err = 1'b0;
        tick();
        expect_idle("err_cleared");
        rst = 1'b0;
    endtask

    task automatic test_full_loop();
        int c;
        beats = 0;
        state = 3'd0;
        tick();
        for (int s = 1; s <= 5; s++) run_stage(3'(s), 10, 0, c);
        checks++;
        if (beats != 810) begin
            errors++;
            $display("FAIL loop_beats: got %0d want 810", beats);
        end
        done = 1'b1;
        state = 3'd0;
        tick();
        expect_idle("loop_done");
        done = 1'b0;
    endtask

    task automatic test_random();
        int c;
        logic [2:0] prev, s;
        prev = 3'd0;
        for (int i = 0; i < 8; i++) begin
            do s = 3'($urandom_range(5, 1)); while (s == prev);
            run_stage(s, int'($urandom_range(60)), 0, c);
            prev = s;
            if ($urandom_range(1) == 1) begin
                state = 3'd0;
                tick();
                expect_idle("random_idle");
                prev = 3'd0;
            end
        end
    endtask

    task automatic test_mid_reset();
        int c;
        run_stage(3'd4, 0, 5, c);
        rst = 1'b1;
        tick();
        expect_idle("mid_reset");
        rst = 1'b0;
        state = 3'd0;
        tick();
        expect_idle("after_mid_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_hold_done();
        test_abort();
        test_reserved();
        test_full_loop();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
